// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: synchronises and debounces request/enable switches for the encoder stage
module switch_debounce_sync #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_raw,
  input  logic             en_raw,
  output logic [WIDTH-1:0] x_db,
  output logic             en_db,
  output logic             any_db,
  output logic             chg
);
  localparam int N = WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  logic [N-1:0] s1_q, s2_q, stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic any_q, any_d, chg_q, chg_d;
  // per channel: count consecutive mismatches, accept the new level on the DB_CYCLES-th one
  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = (s2_q[i] == stb_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + CNT_W'(1);
      stb_d[i] = (s2_q[i] != stb_q[i] && cnt_q[i] == CNT_MAX) ? s2_q[i] : stb_q[i];
    end
    any_d = |stb_d[WIDTH-1:0];
    chg_d = |(stb_d ^ stb_q);
  end
  // synchronisers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      stb_q <= '0;
      cnt_q <= '{default: '0};
      any_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      s1_q  <= {en_raw, x_raw};
      s2_q  <= s1_q;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
      any_q <= any_d;
      chg_q <= chg_d;
    end
  end
  assign x_db   = stb_q[WIDTH-1:0];
  assign en_db  = stb_q[WIDTH];
  assign any_db = any_q;
  assign chg    = chg_q;
endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync: history-based reference model plus directed debounce scenarios
module tb_switch_debounce_sync;
  localparam int W  = 8;
  localparam int DB = 4;
  localparam int HN = 1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] x_raw = 8'hFF;
  logic en_raw = 1'b1;
  logic [W-1:0] x_db;
  logic en_db, any_db, chg;
  int n_tests = 0;
  int n_fail = 0;
  switch_debounce_sync #(.WIDTH(W), .DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .x_raw(x_raw), .en_raw(en_raw),
    .x_db(x_db), .en_db(en_db), .any_db(any_db), .chg(chg)
  );
  always #5 clk = ~clk;
  // model: a channel accepts a new level once its synchronised input (raw sampled
  // two edges earlier, forced to 0 right after reset) has differed from the stable
  // level on each of the last DB edges, none of them at or before the last flip/reset
  logic [W:0] raw_at [HN];
  bit rst_at [HN];
  int last_ev [W+1];
  int e = -1;
  logic [W:0] m_stb = '0;
  bit m_chg = 0, m_any = 0, m_ok = 0;
  function automatic bit sync_at(int k, int ch);
    if (k < 2) return 1'b0;
    if (rst_at[k-1] || rst_at[k-2]) return 1'b0;
    return raw_at[k-2][ch];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      e++;
      if (e >= HN) begin
        $display("FAIL model_history: edge index %0d out of range", e);
        $fatal(1, "history overflow");
      end
      raw_at[e] = {en_raw, x_raw};
      rst_at[e] = rst;
      if (rst) begin
        m_stb = '0;
        m_chg = 0;
        m_any = 0;
        m_ok = 1;
        for (int c = 0; c <= W; c++) last_ev[c] = e;
      end else if (m_ok) begin
        logic [W:0] flips;
        flips = '0;
        for (int c = 0; c <= W; c++) begin
          bit f;
          f = 1;
          for (int k = e - DB + 1; k <= e; k++)
            if (k <= last_ev[c] || sync_at(k, c) == m_stb[c]) f = 0;
          flips[c] = f;
          if (f) last_ev[c] = e;
        end
        m_stb = m_stb ^ flips;
        m_chg = |flips;
        m_any = |m_stb[W-1:0];
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        chk("model_x_db", 32'(x_db), 32'(m_stb[W-1:0]));
        chk("model_en_db", 32'(en_db), 32'(m_stb[W]));
        chk("model_any_db", 32'(any_db), 32'(m_any));
        chk("model_chg", 32'(chg), 32'(m_chg));
      end
    end
  end
  int pulses;
  task automatic step();
    @(negedge clk);
    pulses += int'(chg);
  endtask
  initial begin
    pulses = 0;
    // 1: reset with all switches high
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_x_db", 32'(x_db), 0);
      chk("rst_en_db", 32'(en_db), 0);
      chk("rst_any", 32'(any_db), 0);
      chk("rst_chg", 32'(chg), 0);
    end
    rst = 0; x_raw = 8'h00; en_raw = 0;
    for (int i = 0; i < 3; i++) step();
    // 2: clean press, accepted on the 6th edge
    x_raw = 8'h20;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("press_wait_x", 32'(x_db), 0);
      chk("press_wait_chg", 32'(chg), 0);
    end
    step();
    chk("press_x", 32'(x_db), 32'h20);
    chk("press_any", 32'(any_db), 1);
    chk("press_chg", 32'(chg), 1);
    step();
    chk("press_chg_drop", 32'(chg), 0);
    chk("press_x_hold", 32'(x_db), 32'h20);
    // 3: bounce on bit 3
    pulses = 0;
    x_raw = 8'h28; step(); chk("bounce_x3_a", 32'(x_db[3]), 0);
    x_raw = 8'h20; step(); chk("bounce_x3_b", 32'(x_db[3]), 0);
    x_raw = 8'h28; step(); chk("bounce_x3_c", 32'(x_db[3]), 0);
    x_raw = 8'h20; step(); chk("bounce_x3_d", 32'(x_db[3]), 0);
    x_raw = 8'h28;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("bounce_settle_x3", 32'(x_db[3]), 0);
    end
    step();
    chk("bounce_rise_x", 32'(x_db), 32'h28);
    for (int i = 0; i < 3; i++) step();
    chk("bounce_pulses", 32'(pulses), 1);
    x_raw = 8'h00;
    for (int i = 0; i < 10; i++) step();
    chk("idle_x", 32'(x_db), 0);
    // 4: simultaneous x and en
    x_raw = 8'h81; en_raw = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("simul_wait_x", 32'(x_db), 0);
      chk("simul_wait_en", 32'(en_db), 0);
    end
    step();
    chk("simul_x", 32'(x_db), 32'h81);
    chk("simul_en", 32'(en_db), 1);
    chk("simul_chg", 32'(chg), 1);
    step();
    chk("simul_chg_drop", 32'(chg), 0);
    // 5: release
    pulses = 0;
    x_raw = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("release_wait_x", 32'(x_db), 32'h81);
    end
    step();
    chk("release_x", 32'(x_db), 0);
    chk("release_any", 32'(any_db), 0);
    chk("release_en_kept", 32'(en_db), 1);
    for (int i = 0; i < 3; i++) step();
    chk("release_pulses", 32'(pulses), 1);
    // 6: reset mid-debounce
    x_raw = 8'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_pre_x", 32'(x_db), 0);
    end
    rst = 1;
    step();
    chk("mid_rst_x", 32'(x_db), 0);
    chk("mid_rst_en", 32'(en_db), 0);
    chk("mid_rst_chg", 32'(chg), 0);
    rst = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("mid_wait_x", 32'(x_db), 0);
      chk("mid_wait_chg", 32'(chg), 0);
    end
    step();
    chk("mid_x", 32'(x_db), 32'h20);
    chk("mid_en", 32'(en_db), 1);
    chk("mid_chg", 32'(chg), 1);
    for (int i = 0; i < 3; i++) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
